// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and helpers for the 7-segment scanner
package seg_pkg;

  // Active-low segment patterns, bit 6 = segment g
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Bits needed to count 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/seg_refresh_timer.sv
// rtl/seg_refresh_timer.sv - slot divider, digit index, dead-time flag and frame tick
module seg_refresh_timer
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2,
  localparam int IW = cnt_width(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [IW-1:0] idx,
  output logic          dead,
  output logic          frame_wrap,
  output logic          frame_tick
);

  localparam int DW = cnt_width(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DEAD_END = DW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [DW-1:0] div_cnt;
  logic          slot_end;

  // frame_wrap marks the edge on which the index returns to 0; the top snapshots on it
  assign slot_end   = (div_cnt == DIV_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);
  assign dead       = (div_cnt < DEAD_END);

  // Divider and index advance; frame_tick is high in the first cycle of each frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      if (slot_end) begin
        div_cnt <= '0;
        idx     <= frame_wrap ? '0 : idx + IW'(1);
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/seg_sign_scanner.sv
// rtl/seg_sign_scanner.sv - multiplexed 7-segment scanner with fixed or floating minus sign
module seg_sign_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_blank,
  input  logic                    neg_flag,
  input  logic                    float_sign,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_tick,
  output logic                    sign_ovf
);

  localparam int IW = cnt_width(NUM_DIGITS);

  logic [IW-1:0]           idx;
  logic                    dead;
  logic                    frame_wrap;

  logic [7*NUM_DIGITS-1:0] snap_seg;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic                    snap_neg;
  logic                    snap_float;

  int                      sign_pos;
  logic [6:0]              digit_pat [NUM_DIGITS];
  logic [6:0]              cur_pat;

  seg_refresh_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx        (idx),
    .dead       (dead),
    .frame_wrap (frame_wrap),
    .frame_tick (frame_tick)
  );

  // Capture the inputs once per frame so a frame never mixes old and new values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_seg   <= '1;
      snap_blank <= '1;
      snap_neg   <= 1'b0;
      snap_float <= 1'b0;
      sign_ovf   <= 1'b0;
    end else if (frame_wrap) begin
      snap_seg   <= seg_in;
      snap_blank <= digit_blank;
      snap_neg   <= neg_flag;
      snap_float <= float_sign;
      sign_ovf   <= neg_flag & float_sign & ~digit_blank[NUM_DIGITS-1];
    end
  end

  // Sign goes just above the highest lit digit, clamped to the top digit; fixed mode pins it there
  always_comb begin
    sign_pos = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!snap_blank[k]) sign_pos = (k == NUM_DIGITS - 1) ? k : k + 1;
    end
    if (!snap_float) sign_pos = NUM_DIGITS - 1;
  end

  // Per-digit pattern: minus overrides everything, then blanking, then the raw segments
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (snap_neg && (k == sign_pos)) digit_pat[k] = SEG_MINUS;
      else if (snap_blank[k])          digit_pat[k] = SEG_BLANK;
      else                             digit_pat[k] = snap_seg[7*k +: 7];
    end
    cur_pat = digit_pat[idx];
  end

  // Registered drive: anodes dark during dead time so segments settle before the digit lights
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= dead ? '1 : ~(NUM_DIGITS'(1) << idx);
      seg <= cur_pat;
    end
  end

endmodule

// File: tb/tb_seg_sign_scanner.sv
// tb/tb_seg_sign_scanner.sv - self-checking bench for seg_sign_scanner
module tb_seg_sign_scanner;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int DC = 2;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [27:0]   seg_in;
  logic [3:0]    digit_blank;
  logic          neg_flag;
  logic          float_sign;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          frame_tick;
  logic          sign_ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  // model state
  int          t;
  logic [27:0] m_seg;
  logic [3:0]  m_blank;
  logic        m_neg, m_float, m_ovf;
  int          last_idx, last_div;
  logic [6:0]  last_seg;
  logic        last_ovf;

  typedef struct {
    logic [27:0]     sg;
    logic [3:0]      bl;
    logic            ng;
    logic            fl;
    logic            ovf;
    logic [3:0][6:0] d;
  } vec_t;

  vec_t       tbl [7];
  logic [6:0] got [4];
  logic       got_ovf;

  localparam logic [27:0] PAT = {7'h30, 7'h24, 7'h79, 7'h40};

  seg_sign_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .DEAD_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .digit_blank (digit_blank),
    .neg_flag    (neg_flag),
    .float_sign  (float_sign),
    .an          (an),
    .seg         (seg),
    .frame_tick  (frame_tick),
    .sign_ovf    (sign_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
  endtask

  function automatic logic [6:0] ref_digit(input int k, input logic [27:0] sg, input logic [3:0] bl,
                                           input logic ng, input logic fl);
    int top;
    int pos;
    logic [27:0] s;
    top = -1;
    for (int i = 0; i < ND; i++) if (!bl[i]) top = i;
    if (!fl)            pos = ND - 1;
    else if (top < 0)   pos = 0;
    else if (top == ND - 1) pos = ND - 1;
    else                pos = top + 1;
    if (ng && k == pos) return 7'h3F;
    if (bl[k])          return 7'h7F;
    s = sg >> (7 * k);
    return s[6:0];
  endfunction

  task automatic model_reset();
    t = 0;
    m_seg = '1; m_blank = '1; m_neg = 1'b0; m_float = 1'b0; m_ovf = 1'b0;
  endtask

  // one clock: predict outputs from the previous state, then compare #1 after the edge
  task automatic step();
    logic [27:0] ds;
    logic [3:0]  db, ea;
    logic        dn, df;
    int          dd, di;
    ds = m_seg; db = m_blank; dn = m_neg; df = m_float;
    dd = t % RD;
    di = (t / RD) % ND;
    if ((t + 1) % FRAME == 0) begin
      m_seg = seg_in; m_blank = digit_blank; m_neg = neg_flag; m_float = float_sign;
      m_ovf = neg_flag & float_sign & ~digit_blank[ND-1];
    end
    @(posedge clk);
    t++;
    #1;
    ea = (dd < DC) ? 4'hF : ~(4'b0001 << di);
    check("an", an, ea);
    check("seg", seg, ref_digit(di, ds, db, dn, df));
    check("frame_tick", frame_tick, (t % FRAME == 0));
    check("sign_ovf", sign_ovf, m_ovf);
    last_idx = di; last_div = dd; last_seg = seg; last_ovf = sign_ovf;
  endtask

  task automatic to_snapshot();
    do step(); while (t % FRAME != 0);
  endtask

  task automatic capture_frame(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (last_div >= DC) got[last_idx] = last_seg;
      got_ovf = last_ovf;
    end
  endtask

  initial begin
    tbl[0] = '{PAT, 4'b0000, 1'b0, 1'b0, 1'b0, {7'h30, 7'h24, 7'h79, 7'h40}};
    tbl[1] = '{PAT, 4'b0000, 1'b1, 1'b0, 1'b0, {7'h3F, 7'h24, 7'h79, 7'h40}};
    tbl[2] = '{PAT, 4'b1100, 1'b1, 1'b1, 1'b0, {7'h7F, 7'h3F, 7'h79, 7'h40}};
    tbl[3] = '{PAT, 4'b0000, 1'b1, 1'b1, 1'b1, {7'h3F, 7'h24, 7'h79, 7'h40}};
    tbl[4] = '{PAT, 4'b1111, 1'b1, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h3F}};
    tbl[5] = '{PAT, 4'b0101, 1'b0, 1'b1, 1'b0, {7'h30, 7'h7F, 7'h79, 7'h7F}};
    tbl[6] = '{PAT, 4'b1111, 1'b1, 1'b0, 1'b0, {7'h3F, 7'h7F, 7'h7F, 7'h7F}};

    rst_n = 1'b0;
    seg_in = PAT; digit_blank = 4'b0000; neg_flag = 1'b1; float_sign = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_tick", frame_tick, 1'b0);
    check("reset_ovf", sign_ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // first frame after reset shows blank even though inputs are lit
    capture_frame(FRAME);
    for (int k = 0; k < ND; k++) check($sformatf("post_reset_digit%0d", k), got[k], 7'h7F);

    // table of frame configurations
    for (int i = 0; i < 7; i++) begin
      seg_in = tbl[i].sg; digit_blank = tbl[i].bl; neg_flag = tbl[i].ng; float_sign = tbl[i].fl;
      to_snapshot();
      capture_frame(FRAME);
      for (int k = 0; k < ND; k++)
        check($sformatf("vec%0d_digit%0d", i, k), got[k], tbl[i].d[k]);
      check($sformatf("vec%0d_ovf", i), got_ovf, tbl[i].ovf);
    end

    // tear-free: change seg_in early in a frame, old pattern persists until the next snapshot
    seg_in = PAT; digit_blank = 4'b0000; neg_flag = 1'b0; float_sign = 1'b0;
    to_snapshot();
    capture_frame(10);
    seg_in = '0;
    capture_frame(FRAME - 10);
    check("tear_digit1", got[1], 7'h79);
    check("tear_digit2", got[2], 7'h24);
    check("tear_digit3", got[3], 7'h30);
    capture_frame(FRAME);
    for (int k = 0; k < ND; k++) check($sformatf("tear_new_digit%0d", k), got[k], 7'h00);

    // reset mid-slot at index 2 while a signed, overflowing frame is lit
    seg_in = PAT; digit_blank = 4'b0000; neg_flag = 1'b1; float_sign = 1'b1;
    to_snapshot();
    for (int i = 0; i < FRAME + 8; i++) begin
      if (((t / RD) % ND) == 2 && (t % RD) == 5) break;
      step();
    end
    check("pre_reset_an", an, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_an", an, 4'hF);
    check("midreset_seg", seg, 7'h7F);
    check("midreset_tick", frame_tick, 1'b0);
    check("midreset_ovf", sign_ovf, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    begin
      int first_tick;
      first_tick = -1;
      for (int i = 0; i < FRAME + 8; i++) begin
        step();
        if (frame_tick && first_tick < 0) first_tick = t;
      end
      check("reset_first_tick", first_tick, FRAME);
    end

    // randomized inputs at arbitrary times against the model
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        seg_in      = 28'($urandom());
        digit_blank = 4'($urandom());
        neg_flag    = 1'($urandom());
        float_sign  = 1'($urandom());
      end
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
